reaction_game_fsm: RTL and testbench



---
 rtl/reaction_game_fsm.sv | 166 ++++++++++++++++
 tb/tb_reaction_game_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_fsm.sv
// Reaction-time benchmark controller: click-driven round FSM with screen changes committed on VGA frame boundaries.
// Optional: define REACT_AVG_EN to report the mean of the last four valid trials instead of the last trial.
module reaction_game_fsm #(
  parameter int          CLKS_PER_MS  = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        iClick,
  input  logic        V_SYNC,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic        oEarly
);

  localparam int             PW        = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [11:0]    MS_MAX    = 12'hFFF;

  // Encoding doubles as the screen selector each state asks the drawer to show.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_GO     = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    screen_q, screen_d;
  logic [11:0]   score_q, score_d;
  logic [11:0]   ms_q, ms_d;
  logic [11:0]   delay_q, delay_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          early_q, early_d;
  logic          click_prev_q, vsync_prev_q;
  logic          click_edge, frame_edge, ms_tick, go_committed, trial_done;

`ifdef REACT_AVG_EN
  logic [11:0] hist_q [4];
  logic [11:0] hist_d [4];
  logic [1:0]  ptr_q, ptr_d;
  logic [13:0] sum_q, sum_d;
`endif

  assign reactScreen  = screen_q;
  assign currentScore = score_q;
  assign oEarly       = early_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    click_edge   = iClick & ~click_prev_q;
    frame_edge   = ~V_SYNC & vsync_prev_q;
    ms_tick      = (presc_q == PRESC_MAX);
    go_committed = (screen_q == 2'd2);
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    state_d    = state_q;
    delay_d    = delay_q;
    ms_d       = ms_q;
    early_d    = 1'b0;
    trial_done = 1'b0;
    presc_d    = ms_tick ? '0 : presc_q + PW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (click_edge) begin
          state_d = S_WAIT;
          delay_d = 12'(MIN_DELAY_MS) + {1'b0, lfsr_q[10:0]};
          ms_d    = '0;
        end
      end
      S_WAIT: begin
        if (ms_tick) ms_d = ms_q + 12'd1;
        if (click_edge) begin
          state_d = S_IDLE;
          early_d = 1'b1;
        end else if (ms_q == delay_q) begin
          state_d = S_GO;
          ms_d    = '0;
        end
      end
      S_GO: begin
        // The pre-edge screen decides commitment, so a click on the committing frame edge is still early.
        if (!go_committed) begin
          ms_d    = '0;
          presc_d = '0;
          if (click_edge) begin
            state_d = S_IDLE;
            early_d = 1'b1;
          end
        end else begin
          if (ms_tick && ms_q != MS_MAX) ms_d = ms_q + 12'd1;
          if (click_edge) begin
            state_d    = S_RESULT;
            trial_done = 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (click_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) presc_d = '0;
    screen_d = frame_edge ? state_q : screen_q;
  end

`ifdef REACT_AVG_EN
  always_comb begin
    hist_d  = hist_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    score_d = score_q;
    if (trial_done) begin
      sum_d         = sum_q - {2'b00, hist_q[ptr_q]} + {2'b00, ms_q};
      hist_d[ptr_q] = ms_q;
      ptr_d         = ptr_q + 2'd1;
      score_d       = sum_d[13:2];
    end
  end
`else
  always_comb score_d = trial_done ? ms_q : score_q;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q      <= S_IDLE;
      screen_q     <= '0;
      score_q      <= '0;
      ms_q         <= '0;
      delay_q      <= '0;
      presc_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      early_q      <= 1'b0;
      click_prev_q <= 1'b0;
      vsync_prev_q <= 1'b0;
`ifdef REACT_AVG_EN
      // NOTE: the history is architectural state (empty entries must read 0), so this small array is reset explicitly.
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      screen_q     <= screen_d;
      score_q      <= score_d;
      ms_q         <= ms_d;
      delay_q      <= delay_d;
      presc_q      <= presc_d;
      lfsr_q       <= lfsr_d;
      early_q      <= early_d;
      click_prev_q <= iClick;
      vsync_prev_q <= V_SYNC;
`ifdef REACT_AVG_EN
      hist_q <= hist_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reaction_game_fsm.sv
// Directed self-checking bench for reaction_game_fsm (4 clk per ms, 10 ms minimum delay, 50 clk frames).
module tb_reaction_game_fsm;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        iClick  = 1'b0;
  logic        V_SYNC  = 1'b1;
  logic [1:0]  reactScreen;
  logic [11:0] currentScore;
  logic        oEarly;

  int          n_cmp = 0;
  int          n_err = 0;
  int          vcnt  = 1;
  int          last_score = 0;
  logic [15:0] m_lfsr;
  int          h [4];
  int          hp   = 0;
  int          hsum = 0;

  reaction_game_fsm #(
    .CLKS_PER_MS (4),
    .MIN_DELAY_MS(10),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .iResetn     (rst_n),
    .iClick      (iClick),
    .V_SYNC      (V_SYNC),
    .reactScreen (reactScreen),
    .currentScore(currentScore),
    .oEarly      (oEarly)
  );

  always #5 clk = ~clk;

  // Frame generator: V_SYNC falls when vcnt wraps to 0, so the frame edge is the posedge after a negedge with vcnt==0.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      vcnt   = (vcnt == 49) ? 0 : vcnt + 1;
      V_SYNC = (vcnt >= 5);
    end
  end

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press();
    iClick = 1'b1;
    @(negedge clk);
    iClick = 1'b0;
  endtask

  task automatic wait_screen(input logic [1:0] want, input int budget, input string tag);
    int n = 0;
    while (reactScreen !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, reactScreen, want);
  endtask

  task automatic record_trial(input int meas, output int exp);
`ifdef REACT_AVG_EN
    hsum  = hsum - h[hp] + meas;
    h[hp] = meas;
    hp    = (hp + 1) % 4;
    exp   = hsum / 4;
`else
    exp = meas;
`endif
  endtask

  task automatic clear_history();
    for (int i = 0; i < 4; i++) h[i] = 0;
    hp   = 0;
    hsum = 0;
  endtask

  // Clicks in IDLE once the LFSR gives a delay of 26..89 ms; returns at the first negedge after the click edge.
  task automatic start_round(output int d);
    int k = 0;
    @(negedge clk);
    while ((m_lfsr[10:0] < 11'd16 || m_lfsr[10:0] >= 11'd80) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("lfsr_window", k < 4000, 1);
    d = 10 + int'(m_lfsr[10:0]);
    press();
  endtask

  task automatic play_trial(input int t_ms, input string tag);
    int d, n, meas, exp;
    logic saw_red;
    start_round(d);
    n       = 1;
    saw_red = 1'b0;
    while (reactScreen !== 2'd2 && n < 4 * d + 120) begin
      if (reactScreen === 2'd1) saw_red = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_red_shown"}, saw_red, 1);
    check({tag, "_green_time"}, (n >= 4 * d + 3 && n <= 4 * d + 52), 1);
    repeat (4 * t_ms) @(negedge clk);
    press();
    meas = (t_ms > 4095) ? 4095 : t_ms;
    record_trial(meas, exp);
    last_score = exp;
    check({tag, "_score"}, currentScore, exp);
    check({tag, "_no_early"}, oEarly, 0);
    wait_screen(2'd3, 60, {tag, "_result_screen"});
    press();
    wait_screen(2'd0, 60, {tag, "_back_idle"});
  endtask

  // mode 0: mid-WAIT, 1: WAIT on the cycle msCnt==delay, 2: GO before commit, 3: GO on the committing frame edge.
  task automatic early_round(input int mode, input string tag);
    int d, k;
    logic exp_green, saw_green;
    start_round(d);
    case (mode)
      0:       repeat (20) @(negedge clk);
      1:       repeat (4 * d) @(negedge clk);
      default: repeat (4 * d + 1) @(negedge clk);
    endcase
    if (mode == 3) begin
      k = 0;
      while (vcnt != 0 && k < 60) begin
        @(negedge clk);
        k++;
      end
    end
    exp_green = (mode >= 2) && (vcnt == 0);
    press();
    check({tag, "_pulse"}, oEarly, 1);
    saw_green = (reactScreen === 2'd2);
    @(negedge clk);
    check({tag, "_pulse_len"}, oEarly, 0);
    check({tag, "_score_kept"}, currentScore, last_score);
    repeat (110) begin
      if (reactScreen === 2'd2) saw_green = 1'b1;
      @(negedge clk);
    end
    check({tag, "_green_flash"}, saw_green, exp_green);
    check({tag, "_idle_screen"}, reactScreen, 0);
  endtask

  initial begin
    int d;
    clear_history();
    repeat (3) @(negedge clk);
    check("rst_screen", reactScreen, 0);
    check("rst_score", currentScore, 0);
    check("rst_early", oEarly, 0);
    rst_n = 1'b1;

    play_trial(20, "trial20");
    early_round(0, "early_wait");
    early_round(1, "early_wait_at_delay");
    early_round(2, "early_go");
    early_round(3, "early_go_frame");
    play_trial(5000, "saturate");

    start_round(d);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_screen", reactScreen, 0);
    check("midwait_rst_score", currentScore, 0);
    check("midwait_rst_early", oEarly, 0);
    clear_history();
    last_score = 0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef REACT_AVG_EN
    play_trial(100, "avg100");
    play_trial(200, "avg200");
    play_trial(300, "avg300");
    play_trial(400, "avg400");
    play_trial(500, "avg500");
`else
    play_trial(7, "after_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
